// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with mid-bit sampling, a one-byte valid/ready output buffer,
// and single-cycle frame-error and overrun pulses.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    // state     | meaning
    // IDLE      | line idle, watching for a falling rx
    // START     | timing to the middle of the start bit to reject glitches
    // DATA      | sampling 8 data bits, one per bit period, LSB first
    // STOP      | sampling the stop bit and delivering or discarding the byte
    // WAIT_HIGH | stop bit was low; hold off until the line returns high
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx) begin
                        state   <= START;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rx) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx) begin
                            // Returning to IDLE mid-stop lets a back-to-back start edge be caught.
                            state <= IDLE;
                            if (!valid_o || ready_i) begin
                                data_o  <= shift;
                                valid_o <= 1'b1;
                            end else begin
                                overrun_o <= 1'b1;
                            end
                        end else begin
                            state       <= WAIT_HIGH;
                            frame_err_o <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_HIGH: begin
                    if (rx) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit; cycle offsets are
// measured from t0, the edge that first samples the start bit low.
module tb_uart_rx_byte;

    localparam int N = 16;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int checks = 0;
    int fails  = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int both_seen = 0;

    uart_rx_byte #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err_o) fe_seen++;
        if (overrun_o) ov_seen++;
        if (frame_err_o && overrun_o) both_seen++;
    end

    // Called right after a rising edge (+1); the next edge is t0.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
        rx = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (N) @(posedge clk);
            #1;
        end
        rx = stop_bit;
        repeat (stop_len) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (data_o !== 8'h00) begin fails++; $display("FAIL reset_data got=%h exp=00", data_o); end
        checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin fails++; $display("FAIL reset_frame_err got=%b exp=0", frame_err_o); end
        checks++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL reset_overrun got=%b exp=0", overrun_o); end
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        rx = 1'b1;
        ready_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_single_byte;
        int fe0, ov0;
        fe0 = fe_seen; ov0 = ov_seen;
        ready_i = 1'b1;
        fork
            send_frame(8'hA5, 1'b1, N);
            begin
                repeat (2) @(negedge clk);
                checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL a5_busy_t1 got=%b exp=1", busy_o); end
                repeat (151) @(negedge clk);
                checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL a5_valid_t152 got=%b exp=0", valid_o); end
                repeat (1) @(negedge clk);
                checks++; if (valid_o !== 1'b1) begin fails++; $display("FAIL a5_valid_t153 got=%b exp=1", valid_o); end
                checks++; if (data_o !== 8'hA5) begin fails++; $display("FAIL a5_data got=%h exp=a5", data_o); end
                repeat (1) @(negedge clk);
                checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL a5_valid_t154 got=%b exp=0", valid_o); end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        checks++; if ((fe_seen - fe0) !== 0 || (ov_seen - ov0) !== 0) begin
            fails++; $display("FAIL a5_no_pulses got fe=%0d ov=%0d exp 0 0", fe_seen - fe0, ov_seen - ov0);
        end
        ready_i = 1'b0;
    endtask

    task automatic test_glitch;
        ready_i = 1'b1;
        fork
            begin
                rx = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                rx = 1'b1;
            end
            begin
                repeat (1) @(negedge clk);
                checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL glitch_busy_t0 got=%b exp=0", busy_o); end
                repeat (1) @(negedge clk);
                checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL glitch_busy_t1 got=%b exp=1", busy_o); end
                repeat (7) @(negedge clk);
                checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL glitch_busy_t8 got=%b exp=1", busy_o); end
                repeat (1) @(negedge clk);
                checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL glitch_busy_t9 got=%b exp=0", busy_o); end
                checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL glitch_valid got=%b exp=0", valid_o); end
            end
        join
        repeat (200) @(posedge clk);
        #1;
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL glitch_quiet got valid=%b busy=%b exp 0 0", valid_o, busy_o);
        end
        ready_i = 1'b0;
    endtask

    task automatic test_frame_err;
        int ov0;
        ov0 = ov_seen;
        fork
            send_frame(8'h3C, 1'b0, 40);
            begin
                repeat (153) @(negedge clk);
                checks++; if (frame_err_o !== 1'b0) begin fails++; $display("FAIL ferr_t152 got=%b exp=0", frame_err_o); end
                repeat (1) @(negedge clk);
                checks++; if (frame_err_o !== 1'b1) begin fails++; $display("FAIL ferr_t153 got=%b exp=1", frame_err_o); end
                checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL ferr_valid got=%b exp=0", valid_o); end
                repeat (1) @(negedge clk);
                checks++; if (frame_err_o !== 1'b0) begin fails++; $display("FAIL ferr_t154 got=%b exp=0", frame_err_o); end
                repeat (30) @(negedge clk);
                checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL ferr_busy_t184 got=%b exp=1", busy_o); end
                repeat (1) @(negedge clk);
                checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL ferr_busy_t185 got=%b exp=0", busy_o); end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        checks++; if (valid_o !== 1'b0 || (ov_seen - ov0) !== 0) begin
            fails++; $display("FAIL ferr_after got valid=%b ov=%0d exp 0 0", valid_o, ov_seen - ov0);
        end
    endtask

    task automatic test_back_to_back_overrun;
        ready_i = 1'b0;
        fork
            begin
                send_frame(8'h11, 1'b1, N);
                send_frame(8'h22, 1'b1, N);
            end
            begin
                repeat (154) @(negedge clk);
                checks++; if (valid_o !== 1'b1 || data_o !== 8'h11) begin
                    fails++; $display("FAIL b2b_first got valid=%b data=%h exp 1 11", valid_o, data_o);
                end
                repeat (159) @(negedge clk);
                checks++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL ovr_t312 got=%b exp=0", overrun_o); end
                repeat (1) @(negedge clk);
                checks++; if (overrun_o !== 1'b1) begin fails++; $display("FAIL ovr_t313 got=%b exp=1", overrun_o); end
                checks++; if (frame_err_o !== 1'b0) begin fails++; $display("FAIL ovr_ferr got=%b exp=0", frame_err_o); end
                repeat (1) @(negedge clk);
                checks++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL ovr_t314 got=%b exp=0", overrun_o); end
                checks++; if (valid_o !== 1'b1 || data_o !== 8'h11) begin
                    fails++; $display("FAIL ovr_hold got valid=%b data=%h exp 1 11", valid_o, data_o);
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_simul_consume;
        int ov0;
        ov0 = ov_seen;
        ready_i = 1'b0;
        fork
            send_frame(8'h22, 1'b1, N);
            begin
                repeat (153) @(negedge clk);
                checks++; if (valid_o !== 1'b1 || data_o !== 8'h11) begin
                    fails++; $display("FAIL sim_before got valid=%b data=%h exp 1 11", valid_o, data_o);
                end
                ready_i = 1'b1;
                @(posedge clk);
                #1;
                ready_i = 1'b0;
                @(negedge clk);
                checks++; if (valid_o !== 1'b1 || data_o !== 8'h22) begin
                    fails++; $display("FAIL sim_reload got valid=%b data=%h exp 1 22", valid_o, data_o);
                end
                checks++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL sim_overrun got=%b exp=0", overrun_o); end
                repeat (1) @(negedge clk);
                checks++; if (valid_o !== 1'b1 || data_o !== 8'h22) begin
                    fails++; $display("FAIL sim_hold got valid=%b data=%h exp 1 22", valid_o, data_o);
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        checks++; if ((ov_seen - ov0) !== 0) begin fails++; $display("FAIL sim_no_overrun got=%0d exp=0", ov_seen - ov0); end
    endtask

    task automatic test_reset_mid;
        int fe0, ov0;
        logic [7:0] b;
        fe0 = fe_seen; ov0 = ov_seen;
        b = 8'hC3;
        rx = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (N) @(posedge clk);
            #1;
        end
        rx = b[3];
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL rmid_busy_before got=%b exp=1", busy_o); end
        reset = 1'b1;
        rx = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            fails++; $display("FAIL rmid_state got busy=%b valid=%b exp 0 0", busy_o, valid_o);
        end
        checks++; if (data_o !== 8'h00) begin fails++; $display("FAIL rmid_data got=%h exp=00", data_o); end
        checks++; if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
            fails++; $display("FAIL rmid_pulses got fe=%b ov=%b exp 0 0", frame_err_o, overrun_o);
        end
        repeat (200) @(posedge clk);
        #1;
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL rmid_abandon got valid=%b busy=%b exp 0 0", valid_o, busy_o);
        end
        fork
            send_frame(8'h5A, 1'b1, N);
            begin
                repeat (154) @(negedge clk);
                checks++; if (valid_o !== 1'b1 || data_o !== 8'h5A) begin
                    fails++; $display("FAIL rmid_5a got valid=%b data=%h exp 1 5a", valid_o, data_o);
                end
                ready_i = 1'b1;
                @(negedge clk);
                ready_i = 1'b0;
                @(negedge clk);
                checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rmid_consume got=%b exp=0", valid_o); end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        checks++; if ((fe_seen - fe0) !== 0 || (ov_seen - ov0) !== 0) begin
            fails++; $display("FAIL rmid_no_pulses got fe=%0d ov=%0d exp 0 0", fe_seen - fe0, ov_seen - ov0);
        end
    endtask

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        ready_i = 1'b0;
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_err();
        test_back_to_back_overrun();
        test_simul_consume();
        test_reset_mid();
        checks++; if (both_seen !== 0) begin fails++; $display("FAIL err_ovr_same_cycle got=%0d exp=0", both_seen); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
